// File: rtl/branch_lut_prog.sv
`default_nettype none
// ============================================================================
// Module      : branch_lut_prog
// Description : Programmable branch-target table (relative/absolute entries)
//               with a valid/ready streaming reload port.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_lut_prog #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 11
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [IDX_W-1:0]  Index,
    input  logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] Target,
    input  logic              LoadStart,
    input  logic [IDX_W-1:0]  LoadBase,
    input  logic              LoadValid,
    input  logic [ADDR_W:0]   LoadData,
    input  logic              LoadLast,
    input  logic              LoadAbort,
    output logic              LoadReady,
    output logic              Busy,
    output logic              LoadDone
);

    localparam logic [1:0]        c_st_idle = 2'd0;
    localparam logic [1:0]        c_st_load = 2'd1;
    localparam logic [1:0]        c_st_done = 2'd2;
    localparam logic [IDX_W-1:0]  c_ptr_max = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_entry_default = {1'b0, ADDR_W'(1)};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [ADDR_W:0]   r_table [DEPTH];
    logic [ADDR_W:0]   w_entry;
    logic              w_xfer;
    logic              w_final;

    // Abort takes priority over a word offered in the same cycle.
    assign w_xfer  = (r_state == c_st_load) && LoadValid && !LoadAbort;
    assign w_final = LoadLast || (r_ptr == c_ptr_max);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (LoadStart) begin
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                if (LoadAbort) begin
                    w_state_nxt = c_st_idle;
                end else if (LoadValid && w_final) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        LoadReady = 1'b0;
        Busy      = 1'b0;
        LoadDone  = 1'b0;
        case (r_state)
            c_st_load: begin
                LoadReady = 1'b1;
                Busy      = 1'b1;
            end
            c_st_done: begin
                Busy      = 1'b1;
                LoadDone  = 1'b1;
            end
            default: begin
                LoadReady = 1'b0;
            end
        endcase
    end

    // Pointer saturates at the last entry; the session ends there anyway.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= '0;
        end else if ((r_state == c_st_idle) && LoadStart) begin
            r_ptr <= LoadBase;
        end else if (w_xfer && (r_ptr != c_ptr_max)) begin
            r_ptr <= r_ptr + IDX_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= c_entry_default;
            end
        end else if (w_xfer) begin
            r_table[r_ptr] <= LoadData;
        end
    end

    assign w_entry = r_table[Index];
    assign Target  = w_entry[ADDR_W] ? w_entry[ADDR_W-1:0]
                                     : (PC + w_entry[ADDR_W-1:0]);

endmodule
`default_nettype wire

// File: tb/tb_branch_lut_prog.sv
`default_nettype none
// Testbench for branch_lut_prog: vector table, directed load sequences and
// randomized traffic against a behavioural table/session model.
module tb_branch_lut_prog;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  Index;
    logic [10:0] PC;
    logic [10:0] Target;
    logic        LoadStart;
    logic [3:0]  LoadBase;
    logic        LoadValid;
    logic [11:0] LoadData;
    logic        LoadLast;
    logic        LoadAbort;
    logic        LoadReady;
    logic        Busy;
    logic        LoadDone;

    branch_lut_prog #(.DEPTH(16), .IDX_W(4), .ADDR_W(11)) dut (
        .Clk(Clk), .Reset(Reset), .Index(Index), .PC(PC), .Target(Target),
        .LoadStart(LoadStart), .LoadBase(LoadBase), .LoadValid(LoadValid),
        .LoadData(LoadData), .LoadLast(LoadLast), .LoadAbort(LoadAbort),
        .LoadReady(LoadReady), .Busy(Busy), .LoadDone(LoadDone)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int grp;
        int idx;
        int pc;
        int exp;
    } vec_t;
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Model: table contents plus session phase (0 idle, 1 loading, 2 done).
    logic [11:0] mtbl [16];
    int          mphase;
    int          mptr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mtbl[i] = 12'h001;
        mphase = 0;
        mptr   = 0;
    endfunction

    function automatic int exp_target(input int idx, input int pc);
        logic [11:0] e;
        e = mtbl[idx];
        if (e[11]) return int'(e[10:0]);
        return (pc + int'(e[10:0])) % 2048;
    endfunction

    function automatic void model_step();
        if (mphase == 0) begin
            if (LoadStart) begin
                mptr   = int'(LoadBase);
                mphase = 1;
            end
        end else if (mphase == 1) begin
            if (LoadAbort) begin
                mphase = 0;
            end else if (LoadValid) begin
                mtbl[mptr] = LoadData;
                if (LoadLast || mptr == 15) mphase = 2;
                else mptr = mptr + 1;
            end
        end else begin
            mphase = 0;
        end
    endfunction

    // Called shortly after a rising edge once inputs are set up.
    task automatic cycle();
        #2;
        chk("target", int'(Target), exp_target(int'(Index), int'(PC)));
        chk("ready",  int'(LoadReady), int'(mphase == 1));
        chk("busy",   int'(Busy), int'(mphase != 0));
        chk("done",   int'(LoadDone), int'(mphase == 2));
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        LoadStart = 0; LoadValid = 0; LoadLast = 0; LoadAbort = 0;
        LoadBase = 0; LoadData = 0;
    endtask

    task automatic run_group(input int g);
        foreach (vecs[k]) begin
            if (vecs[k].grp == g) begin
                Index = 4'(vecs[k].idx);
                PC    = 11'(vecs[k].pc);
                #1;
                chk($sformatf("vec%0d_idx%0d", g, vecs[k].idx), int'(Target), vecs[k].exp);
                cycle();
            end
        end
    endtask

    function automatic void add(input int g, input int i, input int p, input int e);
        vec_t v;
        v.grp = g; v.idx = i; v.pc = p; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        bit [4:0] pat;

        for (int i = 0; i < 16; i++) add(0, i, 100, 101);
        add(1, 0, 400, 30);
        add(1, 0, 100, 12'h6F2);
        add(1, 1, 2047, 0);
        add(2, 12, 0, 12'h010);
        add(2, 13, 777, 12'h020);
        add(2, 14, 2047, 12'h030);
        add(2, 15, 1, 12'h040);
        add(2, 11, 50, 51);
        add(2, 0, 400, 30);
        add(3, 1, 0, 12'h100);
        add(3, 2, 0, 12'h103);
        add(3, 3, 0, 12'h104);
        add(3, 4, 9, 10);
        add(4, 4, 10, 15);
        add(4, 5, 10, 16);
        add(4, 6, 10, 11);
        add(4, 9, 10, 11);

        // Power-on reset
        idle_inputs();
        Index = 4'd3; PC = 11'd100;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("rst_target", int'(Target), 101);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_ready", int'(LoadReady), 0);
        chk("rst_done", int'(LoadDone), 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        run_group(0);

        // Relative negative offset, single word with LoadLast
        LoadStart = 1; LoadBase = 0;
        cycle();
        LoadStart = 0; LoadValid = 1; LoadLast = 1; LoadData = {1'b0, 11'h68E};
        #1;
        chk("rel_ready", int'(LoadReady), 1);
        cycle();
        idle_inputs();
        #1;
        chk("rel_done_pulse", int'(LoadDone), 1);
        cycle();
        #1;
        chk("rel_done_clear", int'(LoadDone), 0);
        chk("rel_busy_clear", int'(Busy), 0);
        cycle();
        run_group(1);

        // Absolute burst ending on the last entry
        LoadStart = 1; LoadBase = 12;
        cycle();
        LoadStart = 0; LoadValid = 1;
        for (int k = 0; k < 4; k++) begin
            LoadData = {1'b1, 11'(16 * (k + 1))};
            cycle();
        end
        idle_inputs();
        #1;
        chk("abs_done_pulse", int'(LoadDone), 1);
        cycle();
        run_group(2);

        // Handshake stalls: valid pattern 1,0,0,1,1
        pat = 5'b11001;
        LoadStart = 1; LoadBase = 1;
        cycle();
        LoadStart = 0;
        for (int c = 0; c < 5; c++) begin
            LoadValid = pat[c];
            LoadData  = {1'b1, 11'(256 + c)};
            #1;
            chk("stall_ready", int'(LoadReady), 1);
            cycle();
        end
        LoadValid = 0;
        cycle();
        LoadAbort = 1;
        cycle();
        idle_inputs();
        cycle();
        run_group(3);

        // Abort with simultaneous valid; LoadStart during LOAD ignored
        LoadStart = 1; LoadBase = 4;
        cycle();
        LoadStart = 0; LoadValid = 1; LoadData = {1'b0, 11'd5};
        cycle();
        LoadValid = 0; LoadStart = 1; LoadBase = 9;
        cycle();
        LoadStart = 0; LoadValid = 1; LoadData = {1'b0, 11'd6};
        cycle();
        LoadAbort = 1; LoadData = {1'b0, 11'h7FF};
        cycle();
        idle_inputs();
        #1;
        chk("abort_busy", int'(Busy), 0);
        chk("abort_nodone", int'(LoadDone), 0);
        cycle();
        run_group(4);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            LoadStart = ($urandom % 4) == 0;
            LoadBase  = 4'($urandom);
            LoadValid = 1'($urandom);
            LoadData  = 12'($urandom);
            LoadLast  = ($urandom % 8) == 0;
            LoadAbort = ($urandom % 16) == 0;
            Index     = 4'($urandom);
            PC        = 11'($urandom);
            cycle();
        end

        // Reset in the middle of a load session
        idle_inputs();
        LoadAbort = 1;
        cycle();
        LoadAbort = 0;
        cycle();
        LoadStart = 1; LoadBase = 0;
        cycle();
        LoadStart = 0; LoadValid = 1;
        for (int k = 0; k < 3; k++) begin
            LoadData = {1'b1, 11'(12'h7A0 + k)};
            cycle();
        end
        chk("midload_busy", int'(Busy), 1);
        Reset = 1'b1;
        model_reset();
        PC = 11'd200;
        for (int i = 0; i < 16; i++) begin
            Index = 4'(i);
            #1;
            chk($sformatf("midrst_idx%0d", i), int'(Target), 201);
        end
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_ready", int'(LoadReady), 0);
        chk("midrst_done", int'(LoadDone), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        idle_inputs();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
